// File: rtl/spi_master_pkg.sv
// spi_master_pkg: FSM state encoding and SPI mode constants for the SPI master.
package spi_master_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;
  typedef logic [1:0] spi_mode_t;
  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;
endpackage

// File: rtl/spi_master_param_clk_gen.sv
// spi_clk_gen: half-period counter producing the SCLK level and leading/trailing edge strobes.
module spi_clk_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         run,
  input  logic         clr,
  input  logic         cpol,
  input  logic [W-1:0] div,
  output logic         tick,
  output logic         lead,
  output logic         trail,
  output logic         sclk
);
  logic [W-1:0] cnt;
  logic         ph;
  always_comb begin
    tick  = en && cnt == div;
    lead  = tick && run && !ph;
    trail = tick && run && ph;
    sclk  = cpol ^ ph;
  end
  always_ff @(posedge clk)
    if (rst || !en || clr) begin
      cnt <= '0;
      ph  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + W'(1);
      ph  <= ph ^ (tick && run);
    end
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: multi-byte SPI master with runtime CPOL/CPHA, clock divider, chip select and abort.
module spi_master_param
  import spi_master_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int NUM_CS    = 2,
  parameter int CLK_DIV_W = 8,
  localparam int TW = 8 * MAX_BYTES,
  localparam int BW = $clog2(MAX_BYTES) + 1,
  localparam int CW = NUM_CS > 1 ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 ready_o,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic [CLK_DIV_W-1:0] clk_div_i,
  input  logic [CW-1:0]        cs_sel_i,
  input  logic [BW-1:0]        num_bytes_i,
  input  logic                 abort_i,
  input  logic [TW-1:0]        tx_data_i,
  output logic [TW-1:0]        rx_data_o,
  output logic [BW-1:0]        rx_bytes_o,
  output logic                 rx_valid_o,
  output logic                 busy_o,
  output logic                 spi_sclk_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i,
  output logic [NUM_CS-1:0]    spi_cs_n_o
);
  localparam int PW = BW + 3;
  logic [1:0]           state;
  logic                 arm, cpol_q, cpha_q, abort_q, mosi_q;
  logic [CLK_DIV_W-1:0] div_q;
  logic [CW-1:0]        cs_q;
  logic [BW-1:0]        nb_q;
  logic [TW-1:0]        tx_sr, rx_sr, aligned;
  logic [PW-1:0]        per_cnt;
  logic                 accept, tick, lead, trail, shift_e, samp_e, fin;
  always_comb begin
    ready_o    = state == S_IDLE;
    busy_o     = !ready_o;
    accept     = start_i && ready_o && num_bytes_i != '0 && 32'(num_bytes_i) <= MAX_BYTES && 32'(cs_sel_i) < NUM_CS;
    aligned    = tx_data_i << (8 * (MAX_BYTES - 32'(num_bytes_i)));
    shift_e    = cpha_q ? lead : trail;
    samp_e     = cpha_q ? trail : lead;
    fin        = trail && per_cnt[2:0] == 3'd7 && (per_cnt[PW-1:3] + BW'(1) == nb_q || abort_q || abort_i);
    spi_mosi_o = !ready_o && mosi_q;
    spi_cs_n_o = ready_o ? '1 : ~(NUM_CS'(1) << cs_q);
  end
  // The accept cycle (arm) keeps the divider stopped so SETUP spans one extra cycle before its half-period.
  spi_clk_gen #(.W(CLK_DIV_W)) u_clk_gen (
    .clk   (clk_i),
    .rst   (rst_i),
    .en    ((state == S_SETUP && !arm) || state == S_XFER || state == S_HOLD),
    .run   (state == S_XFER),
    .clr   (state == S_SETUP && abort_i),
    .cpol  (cpol_q),
    .div   (div_q),
    .tick  (tick),
    .lead  (lead),
    .trail (trail),
    .sclk  (spi_sclk_o)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state      <= S_IDLE;
      arm        <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      abort_q    <= 1'b0;
      mosi_q     <= 1'b0;
      div_q      <= '0;
      cs_q       <= '0;
      nb_q       <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      per_cnt    <= '0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      rx_bytes_o <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      arm        <= 1'b0;
      if (state == S_IDLE && accept) begin
        state   <= S_SETUP;
        arm     <= 1'b1;
        cpol_q  <= cpol_i;
        cpha_q  <= cpha_i;
        div_q   <= clk_div_i;
        cs_q    <= cs_sel_i;
        nb_q    <= num_bytes_i;
        abort_q <= 1'b0;
        per_cnt <= '0;
        rx_sr   <= '0;
        {mosi_q, tx_sr} <= cpha_i ? {1'b0, aligned} : {aligned, 1'b0};
      end
      if (state == S_SETUP) state <= abort_i ? S_HOLD : tick ? S_XFER : S_SETUP;
      if (state == S_XFER) begin
        abort_q <= abort_q || abort_i;
        if (samp_e) rx_sr <= {rx_sr[TW-2:0], spi_miso_i};
        if (shift_e) {mosi_q, tx_sr} <= {tx_sr, 1'b0};
        if (trail) per_cnt <= per_cnt + PW'(1);
        if (fin) state <= S_HOLD;
      end
      if (state == S_HOLD && tick) begin
        state      <= S_IDLE;
        rx_valid_o <= 1'b1;
        rx_data_o  <= rx_sr;
        rx_bytes_o <= per_cnt[PW-1:3];
      end
    end
endmodule
